gshare_btb_predictor: RTL and testbench



---
 rtl/gshare_btb_predictor.sv | 108 ++++++++++
 tb/tb_gshare_btb_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: gshare direction (2-bit counters indexed by PC ^ history)
// plus a direct-mapped BTB. EX-stage resolution trains both and repairs the history.
module gshare_btb_predictor #(
    parameter int         GHSR_W    = 8,
    parameter int         BTB_IDX_W = 6,
    parameter logic [1:0] PHT_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       if_pc,
    input  logic              if_fire,
    output logic              pred_btb_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [GHSR_W-1:0] pred_ghsr,
    input  logic              ex_update,
    input  logic [31:0]       ex_pc,
    input  logic [GHSR_W-1:0] ex_ghsr,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic              ex_uncond,
    input  logic              ghsr_restore_en,
    input  logic [GHSR_W-1:0] ghsr_restore
);
    localparam int PHT_D = 2 ** GHSR_W;
    localparam int BTB_D = 2 ** BTB_IDX_W;
    localparam int TAG_W = 32 - BTB_IDX_W - 2;

    logic [1:0]        r_pht        [PHT_D];
    logic              r_btb_valid  [BTB_D];
    logic [TAG_W-1:0]  r_btb_tag    [BTB_D];
    logic [31:0]       r_btb_target [BTB_D];
    logic              r_btb_uncond [BTB_D];
    logic [GHSR_W-1:0] r_ghsr;

    logic [BTB_IDX_W-1:0] w_if_btb_idx;
    logic [TAG_W-1:0]     w_if_tag;
    logic [GHSR_W-1:0]    w_if_pht_idx;
    logic [BTB_IDX_W-1:0] w_ex_btb_idx;
    logic [TAG_W-1:0]     w_ex_tag;
    logic [GHSR_W-1:0]    w_ex_pht_idx;
    logic [1:0]           w_ex_cnt;
    logic [1:0]           w_ex_cnt_nxt;
    logic                 w_unused;

    // PCs are word aligned; the low two bits carry no information.
    assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

    assign w_if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign w_if_tag     = if_pc[31:BTB_IDX_W+2];
    assign w_if_pht_idx = if_pc[GHSR_W+1:2] ^ r_ghsr;

    assign pred_btb_hit = r_btb_valid[w_if_btb_idx] && (r_btb_tag[w_if_btb_idx] == w_if_tag);
    assign pred_taken   = pred_btb_hit && (r_btb_uncond[w_if_btb_idx] || r_pht[w_if_pht_idx][1]);
    assign pred_target  = pred_taken ? r_btb_target[w_if_btb_idx] : (if_pc + 32'd4);
    assign pred_ghsr    = r_ghsr;

    assign w_ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
    assign w_ex_tag     = ex_pc[31:BTB_IDX_W+2];
    assign w_ex_pht_idx = ex_pc[GHSR_W+1:2] ^ ex_ghsr;
    assign w_ex_cnt     = r_pht[w_ex_pht_idx];

    always_comb begin
        w_ex_cnt_nxt = w_ex_cnt;
        if (ex_taken) begin
            if (w_ex_cnt != 2'b11) w_ex_cnt_nxt = w_ex_cnt + 2'd1;
        end else begin
            if (w_ex_cnt != 2'b00) w_ex_cnt_nxt = w_ex_cnt - 2'd1;
        end
    end

    // Restore wins over the speculative shift: the fetch in that cycle is being flushed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ghsr <= '0;
        end else if (ghsr_restore_en) begin
            r_ghsr <= ghsr_restore;
        end else if (if_fire && pred_btb_hit) begin
            r_ghsr <= {r_ghsr[GHSR_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_D; i++) r_pht[i] <= PHT_INIT;
        end else if (ex_update && !ex_uncond) begin
            r_pht[w_ex_pht_idx] <= w_ex_cnt_nxt;
        end
    end

    // Only valid needs a reset; tag/target/uncond are qualified by it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_D; i++) r_btb_valid[i] <= 1'b0;
        end else if (ex_update && ex_taken) begin
            r_btb_valid[w_ex_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && ex_update && ex_taken) begin
            r_btb_tag[w_ex_btb_idx]    <= w_ex_tag;
            r_btb_target[w_ex_btb_idx] <= ex_target;
            r_btb_uncond[w_ex_btb_idx] <= ex_uncond;
        end
    end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed scenarios with literal expectations, plus a
// behavioural model compared against the outputs on every cycle after reset.
module tb_gshare_btb_predictor;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] if_pc;
    logic        if_fire;
    logic        pred_btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghsr;
    logic        ex_update;
    logic [31:0] ex_pc;
    logic [7:0]  ex_ghsr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_uncond;
    logic        ghsr_restore_en;
    logic [7:0]  ghsr_restore;

    int checks = 0;
    int errors = 0;

    gshare_btb_predictor #(.GHSR_W(8), .BTB_IDX_W(6), .PHT_INIT(2'b01)) dut (
        .clk(clk), .reset_n(reset_n), .if_pc(if_pc), .if_fire(if_fire),
        .pred_btb_hit(pred_btb_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_ghsr(pred_ghsr), .ex_update(ex_update), .ex_pc(ex_pc), .ex_ghsr(ex_ghsr),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_uncond(ex_uncond),
        .ghsr_restore_en(ghsr_restore_en), .ghsr_restore(ghsr_restore)
    );

    always #5 clk = ~clk;

    // Model: counters as plain ints, BTB remembers the whole PC of the last taken instruction.
    int          m_pht [256];
    bit          m_vld [64];
    logic [31:0] m_pc  [64];
    logic [31:0] m_tgt [64];
    bit          m_unc [64];
    int          m_ghsr;
    bit          cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic predict(input logic [31:0] pc, output bit hit, output bit tkn,
                           output logic [31:0] tgt);
        int bi, pi;
        bi  = (pc / 4) % 64;
        pi  = ((pc / 4) % 256) ^ m_ghsr;
        hit = m_vld[bi] && ((m_pc[bi] / 4) == (pc / 4));
        tkn = hit && (m_unc[bi] || m_pht[pi] >= 2);
        tgt = tkn ? m_tgt[bi] : pc + 32'd4;
    endtask

    always @(posedge clk) begin
        bit hit, tkn;
        logic [31:0] tgt;
        int pi, bi;
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) m_pht[i] = 1;
            for (int i = 0; i < 64; i++) m_vld[i] = 0;
            m_ghsr = 0;
            cmp_en = 1;
        end else begin
            predict(if_pc, hit, tkn, tgt);
            if (ex_update) begin
                pi = ((ex_pc / 4) % 256) ^ int'(ex_ghsr);
                bi = (ex_pc / 4) % 64;
                if (!ex_uncond) m_pht[pi] = ex_taken ? ((m_pht[pi] < 3) ? m_pht[pi] + 1 : 3)
                                                     : ((m_pht[pi] > 0) ? m_pht[pi] - 1 : 0);
                if (ex_taken) begin
                    m_vld[bi] = 1; m_pc[bi] = ex_pc; m_tgt[bi] = ex_target; m_unc[bi] = ex_uncond;
                end
            end
            if (ghsr_restore_en) m_ghsr = int'(ghsr_restore);
            else if (if_fire && hit) m_ghsr = ((m_ghsr * 2) + (tkn ? 1 : 0)) % 256;
        end
    end

    always @(negedge clk) begin
        bit hit, tkn;
        logic [31:0] tgt;
        if (cmp_en) begin
            predict(if_pc, hit, tkn, tgt);
            chk("model_hit", {31'd0, pred_btb_hit}, {31'd0, hit});
            chk("model_taken", {31'd0, pred_taken}, {31'd0, tkn});
            chk("model_target", pred_target, tgt);
            chk("model_ghsr", {24'd0, pred_ghsr}, m_ghsr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ex_update = 0; if_fire = 0; ghsr_restore_en = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] g, input logic tk,
                       input logic [31:0] tg, input logic unc);
        ex_update = 1; ex_pc = pc; ex_ghsr = g; ex_taken = tk; ex_target = tg; ex_uncond = unc;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic hit,
                        input logic tkn, input logic [31:0] tgt);
        if_pc = pc;
        #2;
        chk({name, "_hit"}, {31'd0, pred_btb_hit}, {31'd0, hit});
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, tkn});
        chk({name, "_target"}, pred_target, tgt);
    endtask

    task automatic restore(input logic [7:0] v);
        ghsr_restore_en = 1; ghsr_restore = v;
        tick();
    endtask

    initial begin
        reset_n = 0; if_pc = 0; if_fire = 0; ex_update = 0; ex_pc = 0; ex_ghsr = 0;
        ex_taken = 0; ex_target = 0; ex_uncond = 0; ghsr_restore_en = 0; ghsr_restore = 0;
        tick(); tick();
        reset_n = 1;

        look("reset", 32'h100, 0, 0, 32'h104);
        chk("reset_ghsr", {24'd0, pred_ghsr}, 32'h0);

        upd(32'h100, 8'h00, 1, 32'h200, 0); tick();
        upd(32'h100, 8'h00, 1, 32'h200, 0); tick();
        look("trained", 32'h100, 1, 1, 32'h200);
        if_fire = 1; tick();
        #2 chk("fire_shift_ghsr", {24'd0, pred_ghsr}, 32'h01);

        upd(32'h40, 8'h01, 1, 32'h80, 1); tick();
        look("jal", 32'h40, 1, 1, 32'h80);
        // PHT[0x11] must still be 01: reach it through 0x100 with history 0x51.
        restore(8'h51);
        look("jal_pht_untouched", 32'h100, 1, 0, 32'h104);

        if_pc = 32'h40; if_fire = 1; ghsr_restore_en = 1; ghsr_restore = 8'hA5;
        #2 chk("restore_pre_taken", {31'd0, pred_taken}, 32'h1);
        tick();
        #2 chk("restore_ghsr", {24'd0, pred_ghsr}, 32'hA5);

        restore(8'h00);
        for (int i = 0; i < 4; i++) begin
            upd(32'h100, 8'h00, 0, 32'h0, 0); tick();
        end
        look("saturated", 32'h100, 1, 0, 32'h104);

        // Same-cycle: evicting write of 0x1100 while 0x100 is looked up sees old entry.
        upd(32'h1100, 8'h00, 1, 32'h300, 0);
        look("same_cycle_old", 32'h100, 1, 0, 32'h104);
        tick();
        look("evicted", 32'h100, 0, 0, 32'h104);
        look("alias_new", 32'h1100, 1, 0, 32'h1104);
        upd(32'h1100, 8'h00, 1, 32'h300, 0); tick();
        look("alias_taken", 32'h1100, 1, 1, 32'h300);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 40; i++) begin
            if_pc = 32'h1000 + 4 * $urandom_range(0, 7);
            if_fire = $urandom_range(0, 1);
            if ($urandom_range(0, 2) != 0)
                upd(32'h1000 + 4 * $urandom_range(0, 7), pred_ghsr, 1'($urandom_range(0, 1)),
                    32'h4000 + 16 * $urandom_range(0, 15), 1'($urandom_range(0, 3) == 0));
            ghsr_restore_en = ($urandom_range(0, 7) == 0);
            ghsr_restore = 8'($urandom);
            tick();
        end

        upd(32'h1100, 8'h00, 1, 32'h300, 0);
        restore(8'h3C);
        if_pc = 32'h1100; if_fire = 1; reset_n = 0;
        upd(32'h40, 8'h00, 1, 32'h500, 0);
        tick();
        reset_n = 1;
        look("reset_mid_1100", 32'h1100, 0, 0, 32'h1104);
        look("reset_mid_40", 32'h40, 0, 0, 32'h44);
        chk("reset_mid_ghsr", {24'd0, pred_ghsr}, 32'h0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
